// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled, glitch-filtered RxD sampling with byte strobe,
// framing-error strobe and a line-idle indication.
module uart_receiver #(
  parameter int ClkFrequency = 12000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       RxD_frame_err,
  output logic       RxD_idle
);

  localparam int      AccWidth = $clog2(ClkFrequency / (Baud * Oversampling)) + 8;
  localparam int      AccW1    = AccWidth + 1;
  localparam longint  IncL     = ((longint'(Baud) * longint'(Oversampling) * (longint'(1) << AccWidth))
                                  + longint'(ClkFrequency) / 2) / longint'(ClkFrequency);
  localparam logic [AccWidth:0] Inc = AccW1'(IncL);
  localparam int      OsW      = $clog2(Oversampling);
  localparam logic [OsW-1:0] HalfCnt = OsW'(Oversampling / 2 - 1);
  localparam logic [OsW-1:0] FullCnt = OsW'(Oversampling - 1);
  localparam int      IdleW    = OsW + 2;
  localparam logic [IdleW-1:0] IdleMax = IdleW'(2 * Oversampling);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t            state_q, state_d;
  logic [AccWidth:0] acc_q;
  logic              tick;
  logic [1:0]        sync_q;
  logic              rxd_s;
  logic [1:0]        filt_cnt_q, filt_cnt_d;
  logic              filt_q, filt_d;
  logic [OsW-1:0]    bit_cnt_q;
  logic [2:0]        idx_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              shift_en;
  logic [IdleW-1:0]  idle_cnt_q;
  logic              mid_pt, bit_pt;

  // Phase accumulator: the registered carry-out is a one-clock tick.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= {1'b0, acc_q[AccWidth-1:0]} + Inc;
  end
  assign tick = acc_q[AccWidth];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RxD};
  end
  assign rxd_s = sync_q[1];

  // Saturating majority-style filter; output only flips at the extremes.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (tick) begin
      if (rxd_s && filt_cnt_q != 2'd3)       filt_cnt_d = filt_cnt_q + 2'd1;
      else if (!rxd_s && filt_cnt_q != 2'd0) filt_cnt_d = filt_cnt_q - 2'd1;
    end
    filt_d = filt_q;
    if (filt_cnt_d == 2'd3)      filt_d = 1'b1;
    else if (filt_cnt_d == 2'd0) filt_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt_q <= 2'd3;
      filt_q     <= 1'b1;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
    end
  end

  assign mid_pt = tick && (bit_cnt_q == HalfCnt);
  assign bit_pt = tick && (bit_cnt_q == FullCnt);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick && !filt_q) state_d = S_START;
      S_START: if (mid_pt) state_d = filt_q ? S_IDLE : S_DATA;
      S_DATA:  if (bit_pt && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_pt) state_d = filt_q ? S_IDLE : S_BREAK;
      S_BREAK: if (tick && filt_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state_q == S_DATA) && bit_pt;
    ready_d  = (state_q == S_STOP) && bit_pt && filt_q;
    err_d    = (state_q == S_STOP) && bit_pt && !filt_q;
  end

  // Bit-time counter is held at zero in IDLE and re-zeroed at mid-start,
  // so every later wrap lands in the middle of a bit.
  always_ff @(posedge clk) begin
    if (rst)                                    bit_cnt_q <= '0;
    else if (state_q == S_IDLE)                 bit_cnt_q <= '0;
    else if (state_q == S_START && mid_pt)      bit_cnt_q <= '0;
    else if (tick)                              bit_cnt_q <= bit_cnt_q + OsW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                     idx_q <= 3'd0;
    else if (state_q == S_START) idx_q <= 3'd0;
    else if (shift_en)           idx_q <= idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {filt_q, shift_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (ready_d) data_q <= shift_q;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               idle_cnt_q <= '0;
    else if (state_q != S_IDLE || !filt_q) idle_cnt_q <= '0;
    else if (tick && idle_cnt_q != IdleMax) idle_cnt_q <= idle_cnt_q + IdleW'(1);
  end

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_frame_err  = err_q;
  assign RxD_idle       = (idle_cnt_q == IdleMax);

endmodule
